bounce_pattern_decoder: RTL
===========================

# bounce_pattern_decoder

Receive-side checker/decoder for the bouncing one-hot shift-register pattern (single '1' sweeping MSB→LSB→MSB). It samples the pattern bus and its terminal-count pulse every clock, recovers position and direction, and counts completed periods. It flags any sample that breaks the legal sequence. It sits downstream of the pattern generator as a monitor and status source for LED/display logic and self-test.

## Interface

- N, 8, pattern width; legal range N ≥ 3
- POS_WIDTH, 3, width of recovered index; 2^POS_WIDTH ≥ N required
- COUNTER_WIDTH, 8, width of period_count and err_count
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- q_in  in  N  sampled pattern bus
- tc_in  in  1  generator terminal-count pulse
- pos  out  POS_WIDTH  index of the '1' in the last accepted sample
- dir  out  1  direction of last move: 1 = toward LSB, 0 = toward MSB
- locked  out  1  decoder tracking a legal sequence
- bounce_lsb  out  1  one-cycle pulse, advance landed on index 0
- bounce_msb  out  1  one-cycle pulse, advance landed on index N-1
- period_count  out  COUNTER_WIDTH  bounce_lsb events while locked, wraps
- err  out  1  one-cycle pulse on sequence violation (locked state only)
- err_code  out  2  last error cause, held until the next error: 01 not one-hot, 10 illegal step, 11 TC mismatch
- err_count  out  COUNTER_WIDTH  errors since reset, saturates at all-ones

## Operation

- One-hot check each cycle: exactly one bit of q_in set; idx = its index.
- FSM states SEARCH, ACQ, LOCKED; reset state SEARCH.
- SEARCH: on one-hot, pos←idx, go ACQ; otherwise stay.
- ACQ: same idx → stay. Adjacent idx (|idx−pos| = 1) → pos←idx, dir←(idx<pos), go LOCKED, locked←1. Non-adjacent one-hot → pos←idx, stay. Not one-hot → SEARCH.
- LOCKED prediction: pred = dir ? (pos==0 ? 1 : pos−1) : (pos==N−1 ? N−2 : pos+1).
- LOCKED, q_in unchanged (hold/freeze) → legal; no state change, no pulses.
- LOCKED, idx == pred → advance: pos←pred, dir←(pred<pos). bounce_lsb if pred==0, which also increments period_count. bounce_msb if pred==N−1.
- LOCKED, any other input → err pulse, err_code set, err_count+1 (saturating), locked←0. Next state ACQ with pos←idx if one-hot (code 10), else SEARCH (code 01).
- Errors are never flagged in SEARCH or ACQ.
- period_count and err_count are cleared only by rst, not by errors or relock.
- Reset in any state: every output 0, state SEARCH, at the next clock edge.

## Timing

- All outputs registered; a sample on edge k is reflected on outputs after edge k.
- Lock latency: 2 distinct adjacent samples. The first valid sample enters ACQ; locked=1 after the edge capturing the second.
- Pulses (err, bounce_lsb, bounce_msb) are high for exactly one cycle per event. Back-to-back events give back-to-back pulses.
- Simultaneous advance-into-0 and TC mismatch: the error takes priority. No bounce_lsb, no period increment.
- Full legal period = 2(N−1) advances; at N=8, 14.

## Configuration

- TC_CHECK_EN defined: in LOCKED, an advance landing on index 0 requires tc_in=1. A legal advance elsewhere, or a hold, requires tc_in=0. A violation gives err_code 11, with the same side-effects as other errors.
- TC_CHECK_EN undefined: tc_in is ignored entirely and code 11 is never produced.

## Test plan

- N=8, rst 1 cycle, then q_in 0x80,0x40,…,0x01,0x02,…,0x80 with tc_in=1 only at 0x01 → locked=1 after the 0x40 sample, pos tracks 7…0…7, one bounce_lsb and one bounce_msb, period_count=1, err never high.
- Locked moving right at 0x10, hold 0x10 for 5 cycles then 0x08 → no err, pos=4 during the hold, then pos=3, dir=1.
- Locked moving right at 0x10, apply 0x04 → err pulse 1 cycle, err_code=10, err_count=1, locked=0, pos=2. Then 0x02 → relock, dir=1.
- Locked, apply 0x18 → err_code=01, locked=0, state SEARCH. 0x18 repeated → no further err.
- Locked at 0x02 moving right, apply 0x01 with tc_in=0: with TC_CHECK_EN, err_code=11 and no bounce_lsb. Without it, bounce_lsb=1 and period_count+1.
- Mid-sequence rst high 1 cycle → all outputs 0 after that edge, including period_count and err_count. Relock requires 2 adjacent samples.

Source files
------------

// File: rtl/bounce_pattern_decoder.sv
// bounce_pattern_decoder
// Monitors a bouncing one-hot pattern (a single '1' sweeping MSB->LSB->MSB).
// It recovers the position and direction of the '1', counts completed periods
// and flags samples that break the legal sequence.
// Optional feature: define TC_CHECK_EN to check the generator's terminal-count
// pulse against the recovered position (error code 11).

module bounce_pattern_decoder #(
    parameter int N             = 8,
    parameter int POS_WIDTH     = 3,
    parameter int COUNTER_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             q_in,
    input  logic                     tc_in,
    output logic [POS_WIDTH-1:0]     pos,
    output logic                     dir,
    output logic                     locked,
    output logic                     bounce_lsb,
    output logic                     bounce_msb,
    output logic [COUNTER_WIDTH-1:0] period_count,
    output logic                     err,
    output logic [1:0]               err_code,
    output logic [COUNTER_WIDTH-1:0] err_count
);

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] ACQ    = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [POS_WIDTH-1:0] LAST = POS_WIDTH'(N - 1);
    localparam logic [POS_WIDTH-1:0] ONE  = POS_WIDTH'(1);
    localparam logic [POS_WIDTH:0]   ONEX = (POS_WIDTH + 1)'(1);

    logic [1:0]           state;
    logic                 isOneHot;
    logic [POS_WIDTH-1:0] idx;
    logic [POS_WIDTH-1:0] pred;
    logic                 isAdjacent;
    logic                 isHold;
    logic                 isAdvance;
    logic                 tcBad;

    // Decode the sample: one-hot test, index of the set bit, and the position the
    // sweep must move to next given the current position and direction.
    always_comb begin
        isOneHot = (q_in != '0) && ((q_in & (q_in - 1'b1)) == '0);
        idx      = '0;
        for (int i = 0; i < N; i++) begin
            if (q_in[i]) begin
                idx = POS_WIDTH'(i);
            end
        end
        if (dir) begin
            pred = (pos == '0) ? ONE : pos - ONE;
        end else begin
            pred = (pos == LAST) ? LAST - ONE : pos + ONE;
        end
        // Widened by one bit so pos+1 cannot wrap to 0 at the top index.
        isAdjacent = ({1'b0, idx} == {1'b0, pos} + ONEX) ||
                     ({1'b0, pos} == {1'b0, idx} + ONEX);
        isHold     = isOneHot && (idx == pos);
        isAdvance  = isOneHot && (idx == pred);
`ifdef TC_CHECK_EN
        // TC must be high exactly on the advance landing on index 0, low otherwise.
        if (isAdvance) begin
            tcBad = (tc_in != (pred == '0));
        end else if (isHold) begin
            tcBad = tc_in;
        end else begin
            tcBad = 1'b0;
        end
`else
        tcBad = 1'b0;
`endif
    end

`ifndef TC_CHECK_EN
    logic unused_tc;
    assign unused_tc = tc_in;
`endif

    // Sequence tracker: acquires the sweep, follows it while locked and records
    // events, errors and counters; pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= SEARCH;
            pos          <= '0;
            dir          <= 1'b0;
            locked       <= 1'b0;
            bounce_lsb   <= 1'b0;
            bounce_msb   <= 1'b0;
            period_count <= '0;
            err          <= 1'b0;
            err_code     <= 2'b00;
            err_count    <= '0;
        end else begin
            bounce_lsb <= 1'b0;
            bounce_msb <= 1'b0;
            err        <= 1'b0;
            case (state)
                SEARCH: begin
                    if (isOneHot) begin
                        pos   <= idx;
                        state <= ACQ;
                    end
                end
                ACQ: begin
                    if (!isOneHot) begin
                        state <= SEARCH;
                    end else if (idx != pos) begin
                        pos <= idx;
                        if (isAdjacent) begin
                            dir    <= (idx < pos);
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (isHold && !tcBad) begin
                        state <= LOCKED;
                    end else if (isAdvance && !tcBad) begin
                        pos <= pred;
                        dir <= (pred < pos);
                        if (pred == '0) begin
                            bounce_lsb   <= 1'b1;
                            period_count <= period_count + 1'b1;
                        end
                        if (pred == LAST) begin
                            bounce_msb <= 1'b1;
                        end
                    end else begin
                        err    <= 1'b1;
                        locked <= 1'b0;
                        if (err_count != '1) begin
                            err_count <= err_count + 1'b1;
                        end
                        if (!isOneHot) begin
                            err_code <= 2'b01;
                            state    <= SEARCH;
                        end else begin
                            err_code <= (isHold || isAdvance) ? 2'b11 : 2'b10;
                            pos      <= idx;
                            state    <= ACQ;
                        end
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule
